// File: rtl/alu_stream_engine.sv
// Streaming ALU: input command FIFO -> single-issue ADD/SUB/MUL/DIV engine -> output result FIFO.
// MUL/DIV occupy the engine for MULDIV_CYCLES cycles; divide by zero returns all ones with err set.
`timescale 1ns/1ps
module alu_stream_engine #(
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned IN_DEPTH      = 8,
  parameter int unsigned OUT_DEPTH     = 8,
  parameter int unsigned MULDIV_CYCLES = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2*DATA_W+1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*DATA_W:0]             out_data,
  output logic                          out_err,
  output logic [$clog2(IN_DEPTH):0]     in_count,
  output logic [$clog2(OUT_DEPTH):0]    out_count,
  output logic                          busy
);

  localparam int unsigned RES_W      = 2*DATA_W + 1;
  localparam int unsigned IN_W       = 2*DATA_W + 2;
  localparam int unsigned OUT_W      = RES_W + 1;
  localparam int unsigned IN_PTR_W   = $clog2(IN_DEPTH);
  localparam int unsigned OUT_PTR_W  = $clog2(OUT_DEPTH);
  localparam int unsigned IN_CNT_W   = IN_PTR_W + 1;
  localparam int unsigned OUT_CNT_W  = OUT_PTR_W + 1;
  localparam int unsigned CNT_W      = $clog2(MULDIV_CYCLES + 1);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t               state_q, state_d;
  logic                 in_push, in_pop, out_push, out_pop;
  logic                 in_full;

  logic [IN_W-1:0]      in_mem [IN_DEPTH];
  logic [IN_PTR_W-1:0]  in_wr_ptr, in_rd_ptr;
  logic [OUT_W-1:0]     out_mem [OUT_DEPTH];
  logic [OUT_PTR_W-1:0] out_wr_ptr, out_rd_ptr;

  logic [1:0]           op_q;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [RES_W-1:0]     result;
  logic                 result_err;

  logic [IN_W-1:0]      in_head;
  logic [1:0]           head_op;

  assign in_full   = (in_count == IN_CNT_W'(IN_DEPTH));
  assign in_ready  = !in_full;
  assign in_push   = in_valid && !in_full;
  assign out_valid = (out_count != '0);
  assign out_pop   = out_ready && out_valid;
  assign busy      = (state_q != IDLE);

  // First-word fall-through head, forced to zero while empty so reset shows clean outputs
  assign out_data  = out_valid ? out_mem[out_rd_ptr][RES_W-1:0] : '0;
  assign out_err   = out_valid ? out_mem[out_rd_ptr][RES_W]     : 1'b0;

  assign in_head   = in_mem[in_rd_ptr];
  assign head_op   = in_head[IN_W-1 -: 2];

  // Input FIFO storage
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= in_data;
  end

  // Input FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_count  <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + IN_PTR_W'(1);
      if (in_pop)  in_rd_ptr <= in_rd_ptr + IN_PTR_W'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + IN_CNT_W'(1);
        2'b01:   in_count <= in_count - IN_CNT_W'(1);
        default: in_count <= in_count;
      endcase
    end
  end

  // Output FIFO storage
  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= {result_err, result};
  end

  // Output FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_count  <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + OUT_PTR_W'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + OUT_PTR_W'(1);
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + OUT_CNT_W'(1);
        2'b01:   out_count <= out_count - OUT_CNT_W'(1);
        default: out_count <= out_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Issue only when the output FIFO has room; that slot stays reserved for the single op in flight
  always_comb begin
    state_d  = state_q;
    in_pop   = 1'b0;
    out_push = 1'b0;
    case (state_q)
      IDLE: begin
        if ((in_count != '0) && (out_count < OUT_CNT_W'(OUT_DEPTH))) begin
          in_pop  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          out_push = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch and execution countdown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (in_pop) begin
      op_q  <= head_op;
      b_q   <= in_head[2*DATA_W-1 -: DATA_W];
      a_q   <= in_head[DATA_W-1:0];
      cnt_q <= head_op[1] ? CNT_W'(MULDIV_CYCLES) : CNT_W'(1);
    end else if (state_q == EXEC) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Arithmetic on the latched operands
  always_comb begin
    result     = '0;
    result_err = 1'b0;
    case (op_q)
      2'd0: result = RES_W'(a_q) + RES_W'(b_q);
      2'd1: result = RES_W'(a_q) - RES_W'(b_q);
      2'd2: result = RES_W'(a_q) * RES_W'(b_q);
      default: begin
        if (b_q == '0) begin
          result     = '1;
          result_err = 1'b1;
        end else begin
          result = RES_W'(a_q / b_q);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_alu_stream_engine.sv
// Directed bench for alu_stream_engine: reset, latency, arithmetic, backpressure,
// mid-operation reset and a randomised scoreboard run.
`timescale 1ns/1ps
module tb_alu_stream_engine;

  localparam int unsigned DW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_data;
  logic        out_err;
  logic [3:0]  in_count;
  logic [3:0]  out_count;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_stream_engine #(.DATA_W(DW), .IN_DEPTH(8), .OUT_DEPTH(8), .MULDIV_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .in_count(in_count), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = {op, b, a};
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [8:0] data, input logic err);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"},  32'(out_data),  32'(data));
    check({tag, "_err"},   32'(out_err),   32'(err));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [9:0] model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    int   r;
    logic e;
    e = 1'b0;
    case (op)
      2'd0: r = int'(a) + int'(b);
      2'd1: r = int'(a) - int'(b);
      2'd2: r = int'(a) * int'(b);
      default: begin
        if (b == 4'd0) begin
          r = 511;
          e = 1'b1;
        end else begin
          r = int'(a) / int'(b);
        end
      end
    endcase
    return {e, 9'(r)};
  endfunction

  initial begin
    int          n;
    int          acc;
    logic        seen;
    logic [9:0]  sb[$];
    logic [9:0]  exp;
    logic [1:0]  rop;
    logic [3:0]  ra, rb;
    int          sent, got, cyc;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    check("rst_in_count",  32'(in_count),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    reset = 1'b0;
    tick();

    // T1: ADD latency and value
    push(2'd0, 4'hF, 4'h1);
    check("t1_valid_e0", 32'(out_valid), 32'd0);
    tick();
    check("t1_valid_e1", 32'(out_valid), 32'd0);
    check("t1_busy_e1",  32'(busy),      32'd1);
    tick();
    check("t1_valid_e2", 32'(out_valid), 32'd1);
    pop_expect("t1", 9'h010, 1'b0);

    // T2: MUL latency on an idle engine, then SUB/MUL/DIV ordering
    push(2'd2, 4'd3, 4'd5);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("t2_mul_latency", 32'(n), 32'd4);
    pop_expect("t2_mul", 9'h00F, 1'b0);
    push(2'd1, 4'd2, 4'd5);
    push(2'd2, 4'd15, 4'd15);
    push(2'd3, 4'd9, 4'd2);
    pop_expect("t2_sub", 9'h1FD, 1'b0);
    pop_expect("t2_mul2", 9'h0E1, 1'b0);
    pop_expect("t2_div", 9'h004, 1'b0);

    // T3: divide by zero, error does not stick
    push(2'd3, 4'd7, 4'd0);
    push(2'd0, 4'd1, 4'd2);
    pop_expect("t3_div0", 9'h1FF, 1'b1);
    pop_expect("t3_add",  9'h003, 1'b0);

    // T4: output backpressure fills both FIFOs
    acc = 0;
    out_ready = 1'b0;
    for (int k = 0; k < 80; k++) begin
      in_valid = (acc < 20);
      in_data  = {2'd0, 4'd3, 4'(acc)};
      if (in_valid && in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("t4_accepted",  32'(acc),       32'd16);
    check("t4_in_count",  32'(in_count),  32'd8);
    check("t4_out_count", 32'(out_count), 32'd8);
    check("t4_in_ready",  32'(in_ready),  32'd0);
    check("t4_busy",      32'(busy),      32'd0);
    for (int j = 0; j < 16; j++) pop_expect("t4_drain", 9'(j + 3), 1'b0);
    repeat (6) tick();
    check("t4_out_empty", 32'(out_count), 32'd0);
    check("t4_in_empty",  32'(in_count),  32'd0);

    // T5: reset during the second EXEC cycle of a MUL with both FIFOs partly full
    push(2'd0, 4'd1, 4'd1);
    push(2'd0, 4'd2, 4'd2);
    n = 0;
    while (!(out_count == 4'd2 && !busy) && n < 20) begin
      tick();
      n++;
    end
    check("t5_prefill", 32'(out_count), 32'd2);
    push(2'd2, 4'd3, 4'd3);
    push(2'd0, 4'd4, 4'd4);
    push(2'd0, 4'd5, 4'd5);
    check("t5_busy_pre",  32'(busy),     32'd1);
    check("t5_in_pre",    32'(in_count), 32'd2);
    reset = 1'b1;
    #1;
    check("t5_in_count",  32'(in_count),  32'd0);
    check("t5_out_count", 32'(out_count), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_in_ready",  32'(in_ready),  32'd1);
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen = seen | out_valid;
    end
    check("t5_no_output", 32'(seen), 32'd0);

    // T6: random traffic against a scoreboard
    sent = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 30000) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_data   = {rop, rb, ra};
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check("t6_result", 32'({out_err, out_data}), 32'(exp));
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(rop, ra, rb));
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t6_done", 32'(got), 32'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
